// File: rtl/div_clk_monitor_if.sv
// Measurement bus between a divided-clock monitor and its consumer.
// Carries duty_err only when DIV_MON_DUTY_CHECK_EN is defined.
interface div_clk_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clk_div;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             mismatch;
    logic             timeout;
`ifdef DIV_MON_DUTY_CHECK_EN
    logic             duty_err;
`endif

    modport master (
        input  clk_div,
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output mismatch,
`ifdef DIV_MON_DUTY_CHECK_EN
        output duty_err,
`endif
        output timeout
    );

    modport slave (
        output clk_div,
        input  period,
        input  high_time,
        input  meas_valid,
        input  locked,
        input  mismatch,
`ifdef DIV_MON_DUTY_CHECK_EN
        input  duty_err,
`endif
        input  timeout
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures period/high time of clk_div in clk_in cycles, tracks lock to ratio N.
// Optional duty-cycle error flag enabled by defining DIV_MON_DUTY_CHECK_EN.
module div_clk_monitor #(
    parameter int N          = 7,
    parameter int CNT_W      = 8,
    parameter int MAX_PERIOD = 255,
    parameter int LOCK_CNT   = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    div_clk_monitor_if.master   mon
);
    localparam int LC_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             s1_r, s2_r, s3_r;
    logic             rise_s;
    logic             capture_s;
    logic             tmo_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] period_new_s;
    logic             period_ok_s;
    logic [LC_W-1:0]  lc_r;
    logic [LC_W-1:0]  lc_nxt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_time_r;
    logic             meas_valid_r;
    logic             locked_r;
    logic             mismatch_r;
    logic             timeout_r;

`ifdef DIV_MON_DUTY_CHECK_EN
    logic             duty_err_r;

    // True when twice the high time differs from the period by more than one cycle.
    function automatic logic duty_off(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] p);
        logic [CNT_W:0] th;
        logic [CNT_W:0] pp;
        logic [CNT_W:0] d;
        th = {h, 1'b0};
        pp = {1'b0, p};
        if (th > pp) begin
            d = th - pp;
        end else begin
            d = pp - th;
        end
        return (d > (CNT_W+1)'(1));
    endfunction

    assign mon.duty_err = duty_err_r;
`endif

    assign rise_s = s2_r & ~s3_r;

    // Two-flop synchroniser plus history flop for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= mon.clk_div;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus capture/timeout decode; a rise at the threshold wins over timeout.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (rise_s) begin
                    state_nxt_s = ST_MEAS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_MEAS: begin
                if (rise_s) begin
                    capture_s = 1'b1;
                end else if (cnt_r >= CNT_W'(MAX_PERIOD - 1)) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_MEAS;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT;
            end
        endcase
    end

    // Lock counter saturates at LOCK_CNT and clears on any off-ratio period.
    always_comb begin
        period_new_s = cnt_r + CNT_W'(1);
        period_ok_s  = (period_new_s == CNT_W'(N));
        if (!period_ok_s) begin
            lc_nxt_s = LC_W'(0);
        end else if (lc_r == LC_W'(LOCK_CNT)) begin
            lc_nxt_s = lc_r;
        end else begin
            lc_nxt_s = lc_r + LC_W'(1);
        end
    end

    // Measurement counters, captured results and status flags.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            hcnt_r       <= {CNT_W{1'b0}};
            lc_r         <= {LC_W{1'b0}};
            period_r     <= {CNT_W{1'b0}};
            high_time_r  <= {CNT_W{1'b0}};
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            mismatch_r   <= 1'b0;
            timeout_r    <= 1'b0;
`ifdef DIV_MON_DUTY_CHECK_EN
            duty_err_r   <= 1'b0;
`endif
        end else begin
            meas_valid_r <= capture_s;
            timeout_r    <= tmo_s;
            if (state_r == ST_WAIT) begin
                if (rise_s) begin
                    cnt_r  <= {CNT_W{1'b0}};
                    hcnt_r <= CNT_W'(1);
                end
            end else if (capture_s) begin
                period_r    <= period_new_s;
                high_time_r <= hcnt_r;
                cnt_r       <= {CNT_W{1'b0}};
                hcnt_r      <= CNT_W'(1);
                lc_r        <= lc_nxt_s;
                locked_r    <= (lc_nxt_s == LC_W'(LOCK_CNT));
                if (!period_ok_s && locked_r) begin
                    mismatch_r <= 1'b1;
                end
`ifdef DIV_MON_DUTY_CHECK_EN
                duty_err_r  <= duty_off(hcnt_r, period_new_s);
`endif
            end else if (tmo_s) begin
                lc_r     <= {LC_W{1'b0}};
                locked_r <= 1'b0;
            end else begin
                if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                if (s2_r && (hcnt_r != {CNT_W{1'b1}})) begin
                    hcnt_r <= hcnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign mon.period     = period_r;
    assign mon.high_time  = high_time_r;
    assign mon.meas_valid = meas_valid_r;
    assign mon.locked     = locked_r;
    assign mon.mismatch   = mismatch_r;
    assign mon.timeout    = timeout_r;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: lock, ratio change, timeout, reset, duty flag.
module tb_div_clk_monitor;
    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tmo_seen = 0;

    int   ratio_v = 7;
    int   hi_v    = 4;
    int   cur_r   = 7;
    int   cur_h   = 4;
    int   ph      = 0;
    bit   gen_en  = 1'b0;

    div_clk_monitor_if #(.CNT_W(8)) bus ();

    div_clk_monitor #(
        .N(7), .CNT_W(8), .MAX_PERIOD(255), .LOCK_CNT(4)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Clock divider model; new ratio/high settings take effect at a rising edge.
    always begin
        @(posedge clk_in);
        #1;
        if (!gen_en) begin
            bus.clk_div = 1'b0;
            ph = 0;
        end else begin
            if (ph == 0) begin
                cur_r = ratio_v;
                cur_h = hi_v;
            end
            bus.clk_div = (ph < cur_h);
            ph = (ph + 1 == cur_r) ? 0 : ph + 1;
        end
    end

    always @(negedge clk_in) begin
        if (bus.timeout === 1'b1) tmo_seen++;
    end

    typedef struct {
        int ratio;
        int hi;
        int ncap;
        int exp_period;
        int exp_high;
        int lock_at;
        int exp_mismatch;
        int exp_duty;
    } row_t;

    row_t rows [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_cap(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (bus.meas_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("capture_wait", 0, 1);
    endtask

    task automatic cycles_to_cap(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_in);
            if (bus.meas_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int n;
        bus.clk_div = 1'b0;
        rows[0] = '{7, 3, 6, 7, 3, 0,    0, 0};
        rows[1] = '{5, 2, 6, 5, 2, 1000, 1, 0};
        rows[2] = '{8, 4, 4, 8, 4, 1000, 1, 0};
        rows[3] = '{8, 6, 4, 8, 6, 1000, 1, 1};
        rows[4] = '{7, 4, 6, 7, 4, 3,    1, 0};

        repeat (3) @(negedge clk_in);
        chk("rst_period", int'(bus.period), 0);
        chk("rst_flags", int'({bus.meas_valid, bus.locked, bus.mismatch, bus.timeout}), 0);
        rst = 1'b1;

        // Acquire lock at ratio 7; locked exactly from the 4th measurement.
        ratio_v = 7; hi_v = 4;
        @(negedge clk_in);
        gen_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cap(got);
            chk("lock_period", int'(bus.period), 7);
            chk("lock_high_rng", int'(bus.high_time >= 8'd3 && bus.high_time <= 8'd4), 1);
            chk("lock_locked", int'(bus.locked), (i >= 3) ? 1 : 0);
            chk("lock_mismatch", int'(bus.mismatch), 0);
`ifdef DIV_MON_DUTY_CHECK_EN
            chk("lock_duty", int'(bus.duty_err), 0);
`endif
        end
        chk("lock_no_timeout", tmo_seen, 0);

        // Table: each row switches settings; the first capture still covers the old period.
        for (int r = 0; r < 5; r++) begin
            ratio_v = rows[r].ratio;
            hi_v    = rows[r].hi;
            wait_cap(got);
            for (int j = 0; j < rows[r].ncap; j++) begin
                wait_cap(got);
                chk($sformatf("row%0d_period", r), int'(bus.period), rows[r].exp_period);
                chk($sformatf("row%0d_high", r), int'(bus.high_time), rows[r].exp_high);
                chk($sformatf("row%0d_locked", r), int'(bus.locked), (j >= rows[r].lock_at) ? 1 : 0);
                chk($sformatf("row%0d_mismatch", r), int'(bus.mismatch), rows[r].exp_mismatch);
`ifdef DIV_MON_DUTY_CHECK_EN
                chk($sformatf("row%0d_duty", r), int'(bus.duty_err), rows[r].exp_duty);
`endif
            end
        end

        // Timeout: clk_div held low right after a capture; pulse 255 cycles later.
        gen_en = 1'b0;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk_in);
            if (i == 254) chk("tmo_locked_before", int'(bus.locked), 1);
            if (bus.timeout === 1'b1) begin
                n = i;
                chk("tmo_locked_drop", int'(bus.locked), 0);
                break;
            end
        end
        chk("tmo_delay", n, 255);
        @(negedge clk_in);
        chk("tmo_pulse_width", int'(bus.timeout), 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (bus.meas_valid === 1'b1) n++;
        end
        chk("tmo_quiet_valid", n, 0);
        chk("tmo_count", tmo_seen, 1);

        // Restart: first measurement needs two rises.
        ratio_v = 7; hi_v = 4;
        gen_en = 1'b1;
        cycles_to_cap(n);
        chk("restart_latency", n, 11);
        chk("restart_period", int'(bus.period), 7);
        chk("restart_locked", int'(bus.locked), 0);
        for (int i = 0; i < 4; i++) wait_cap(got);
        chk("relock_locked", int'(bus.locked), 1);
        chk("relock_mismatch_sticky", int'(bus.mismatch), 1);

        // Asynchronous reset mid-period clears everything immediately.
        repeat (3) @(negedge clk_in);
        #2;
        rst = 1'b0;
        gen_en = 1'b0;
        #1;
        chk("arst_period", int'(bus.period), 0);
        chk("arst_high", int'(bus.high_time), 0);
        chk("arst_flags", int'({bus.meas_valid, bus.locked, bus.mismatch, bus.timeout}), 0);
        repeat (3) @(negedge clk_in);
        chk("arst_hold_flags", int'({bus.locked, bus.mismatch}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        gen_en = 1'b1;
        cycles_to_cap(n);
        chk("post_rst_latency", n, 11);
        chk("post_rst_period", int'(bus.period), 7);
        chk("post_rst_high", int'(bus.high_time), 4);
        chk("post_rst_mismatch", int'(bus.mismatch), 0);
        chk("total_timeouts", tmo_seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
